// File: rtl/exe_muldiv_unit_pkg.sv
// Shared execute-stage widths, command codes and muldiv command classification helpers.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
`ifndef EXE_MULDIV_DEFINES_SVH
`define EXE_MULDIV_DEFINES_SVH
`define WORD_LEN        32
`define EXE_CMD_LEN     4
`define REG_32_ADDR_LEN 5
`define EXE_ADD         4'h0
`define EXE_MUL         4'h8
`define EXE_MULH        4'h9
`define EXE_MULHU       4'hA
`define EXE_DIV         4'hB
`define EXE_DIVU        4'hC
`define EXE_REM         4'hD
`define EXE_REMU        4'hE
`endif

package exe_muldiv_unit_pkg;

    // Any command that this unit executes
    function automatic logic is_muldiv(input logic [`EXE_CMD_LEN-1:0] cmd);
        return (cmd == `EXE_MUL)  || (cmd == `EXE_MULH) || (cmd == `EXE_MULHU) ||
               (cmd == `EXE_DIV)  || (cmd == `EXE_DIVU) || (cmd == `EXE_REM)   ||
               (cmd == `EXE_REMU);
    endfunction

    // Commands that use the shift-subtract divider
    function automatic logic is_div(input logic [`EXE_CMD_LEN-1:0] cmd);
        return (cmd == `EXE_DIV) || (cmd == `EXE_DIVU) ||
               (cmd == `EXE_REM) || (cmd == `EXE_REMU);
    endfunction

    // Commands that operate on magnitudes and sign-correct afterwards
    function automatic logic is_signed_op(input logic [`EXE_CMD_LEN-1:0] cmd);
        return (cmd == `EXE_MULH) || (cmd == `EXE_DIV) || (cmd == `EXE_REM);
    endfunction

endpackage

// File: rtl/exe_muldiv_datapath.sv
// Iterative radix-2 datapath: 64-bit accumulator, shift-add multiply / restoring divide step.
// Latency: one iteration per i_step cycle; 32 steps give the full product or quotient/remainder.
// Backpressure: none; the controlling FSM decides when to load and step.
module exe_muldiv_datapath #(
    parameter int DATA_W = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_is_div,
    input  logic [DATA_W-1:0]     i_op_a,
    input  logic [DATA_W-1:0]     i_op_b,
    output logic [2*DATA_W-1:0]   o_acc
);

    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   opb_q;
    logic                div_q;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_diff;
    logic [2*DATA_W-1:0] acc_d;

    // One iteration: multiply keeps {partial, multiplier}, divide keeps {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
        rem_diff = rem_sh - {1'b0, opb_q};
        if (!div_q) begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end else if (!rem_diff[DATA_W]) begin
            acc_d = {rem_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
    end

    // Accumulator and operand B registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
        end else if (i_load) begin
            acc_q <= {{DATA_W{1'b0}}, i_op_a};
            opb_q <= i_op_b;
            div_q <= i_is_div;
        end else if (i_step) begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multi-cycle MUL/MULH/MULHU/DIV/DIVU/REM/REMU unit with one-cycle result pulse.
// Latency: 35 cycles from accept to o_valid (normal), 2 cycles for divide special cases.
// Backpressure: o_stall holds the ID-to-EXE register while an op is accepted, iterating or fixing up.
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = `WORD_LEN,
    parameter int CMD_W  = `EXE_CMD_LEN,
    parameter int ADDR_W = `REG_32_ADDR_LEN
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_valid,
    input  logic [CMD_W-1:0]  i_Execute_cmd,
    input  logic [DATA_W-1:0] i_value1,
    input  logic [DATA_W-1:0] i_value2,
    input  logic [ADDR_W-1:0] i_dest,
    input  logic              i_writeback_en,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_result,
    output logic [ADDR_W-1:0] o_dest,
    output logic              o_writeback_en
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [4:0]          cnt_q;
    logic [CMD_W-1:0]    cmd_q;
    logic                neg_q;
    logic                wb_q;
    logic                accept;
    logic                special;
    logic [DATA_W-1:0]   special_res;
    logic                sgn;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                neg_d;
    logic                dp_load, dp_step;
    logic                stall_raw;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_neg;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [DATA_W-1:0]   fix_res;

    assign accept = (state_q == IDLE) && i_valid && is_muldiv(i_Execute_cmd) && !i_flush;

    // Operand magnitudes, result sign and divide corner cases decided at accept time
    always_comb begin
        sgn     = is_signed_op(i_Execute_cmd);
        a_neg   = sgn && i_value1[DATA_W-1];
        b_neg   = sgn && i_value2[DATA_W-1];
        mag_a   = a_neg ? -i_value1 : i_value1;
        mag_b   = b_neg ? -i_value2 : i_value2;
        neg_d   = (i_Execute_cmd == `EXE_REM) ? a_neg : (a_neg ^ b_neg);
        special = 1'b0;
        special_res = '0;
        if (is_div(i_Execute_cmd) && (i_value2 == '0)) begin
            special     = 1'b1;
            special_res = ((i_Execute_cmd == `EXE_DIV) || (i_Execute_cmd == `EXE_DIVU)) ?
                          '1 : i_value1;
        end else if (((i_Execute_cmd == `EXE_DIV) || (i_Execute_cmd == `EXE_REM)) &&
                     (i_value1 == MIN_NEG) && (i_value2 == '1)) begin
            special     = 1'b1;
            special_res = (i_Execute_cmd == `EXE_DIV) ? MIN_NEG : '0;
        end
    end

    exe_muldiv_datapath #(.DATA_W(DATA_W)) u_datapath (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .i_load      (dp_load),
        .i_step      (dp_step),
        .i_is_div    (is_div(i_Execute_cmd)),
        .i_op_a      (mag_a),
        .i_op_b      (mag_b),
        .o_acc       (acc)
    );

    // Sign correction of the finished accumulator
    always_comb begin
        acc_neg = -acc;
        quo_fix = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem_fix = neg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        case (cmd_q)
            `EXE_MUL:              fix_res = acc[DATA_W-1:0];
            `EXE_MULH:             fix_res = neg_q ? acc_neg[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            `EXE_MULHU:            fix_res = acc[2*DATA_W-1:DATA_W];
            `EXE_DIV, `EXE_DIVU:   fix_res = quo_fix;
            default:               fix_res = rem_fix;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // FSM next-state logic; flush aborts any busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (i_flush)              state_d = IDLE;
                else if (cnt_q == 5'd31)  state_d = FIX;
            end
            FIX:  state_d = i_flush ? IDLE : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stall, result pulse and datapath controls
    always_comb begin
        stall_raw = 1'b0;
        o_valid   = 1'b0;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        case (state_q)
            IDLE: begin
                stall_raw = accept;
                dp_load   = accept && !special;
            end
            CALC: begin
                stall_raw = !i_flush;
                dp_step   = !i_flush;
            end
            FIX:  stall_raw = !i_flush;
            DONE: o_valid   = !i_flush;
            default: ;
        endcase
        o_stall = stall_raw && i_sys_rst_n;
    end

    // Iteration counter, running only while in CALC
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)           cnt_q <= '0;
        else if (state_q == CALC)   cnt_q <= cnt_q + 5'd1;
        else                        cnt_q <= '0;
    end

    // Instruction capture at accept and result registration
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            cmd_q    <= '0;
            neg_q    <= 1'b0;
            wb_q     <= 1'b0;
            o_dest   <= '0;
            o_result <= '0;
        end else begin
            if (accept) begin
                cmd_q  <= i_Execute_cmd;
                neg_q  <= neg_d;
                wb_q   <= i_writeback_en;
                o_dest <= i_dest;
                if (special) o_result <= special_res;
            end
            if ((state_q == FIX) && !i_flush) o_result <= fix_res;
        end
    end

    assign o_writeback_en = wb_q && o_valid;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed self-checking bench for exe_muldiv_unit.
// Latency: checks 34-cycle stall / 35th-cycle result and 1-cycle special-case timing.
// Backpressure: holds the instruction on its inputs while o_stall is high.
module tb_exe_muldiv_unit;

    localparam logic [3:0] C_ADD   = 4'h0;
    localparam logic [3:0] C_MUL   = 4'h8;
    localparam logic [3:0] C_MULH  = 4'h9;
    localparam logic [3:0] C_MULHU = 4'hA;
    localparam logic [3:0] C_DIV   = 4'hB;
    localparam logic [3:0] C_DIVU  = 4'hC;
    localparam logic [3:0] C_REM   = 4'hD;
    localparam logic [3:0] C_REMU  = 4'hE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [3:0]  i_cmd;
    logic [31:0] i_value1, i_value2;
    logic [4:0]  i_dest;
    logic        i_wb;
    logic        i_flush;
    logic        o_stall, o_valid, o_wb;
    logic [31:0] o_result;
    logic [4:0]  o_dest;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exe_muldiv_unit dut (
        .i_sys_clk      (clk),
        .i_sys_rst_n    (rst_n),
        .i_valid        (i_valid),
        .i_Execute_cmd  (i_cmd),
        .i_value1       (i_value1),
        .i_value2       (i_value2),
        .i_dest         (i_dest),
        .i_writeback_en (i_wb),
        .i_flush        (i_flush),
        .o_stall        (o_stall),
        .o_valid        (o_valid),
        .o_result       (o_result),
        .o_dest         (o_dest),
        .o_writeback_en (o_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction, hold it while stalled, and check the result pulse.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dest, input logic wb,
                          input logic [31:0] exp_res, input int exp_stall);
        int          stalls = 0;
        int          c = 0;
        logic        got = 1'b0;
        logic [31:0] res = '0;
        logic [4:0]  d = '0;
        logic        w = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_cmd = cmd; i_value1 = a; i_value2 = b; i_dest = dest; i_wb = wb;
        while (!got && c < 100) begin
            #1;
            if (o_valid) begin
                got = 1'b1; res = o_result; d = o_dest; w = o_wb;
            end else begin
                if (o_stall) stalls++;
                c++;
                @(negedge clk);
            end
        end
        chk({tag, "_valid"}, {31'd0, got}, 32'd1);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
        chk({tag, "_dest"}, {27'd0, d}, {27'd0, dest});
        chk({tag, "_wb"}, {31'd0, w}, {31'd0, wb});
    endtask

    // Hold inputs for n cycles, counting any stall or valid seen.
    task automatic watch_quiet(input string tag, input int n);
        int st = 0;
        int vl = 0;
        for (int k = 0; k < n; k++) begin
            #1;
            if (o_stall) st++;
            if (o_valid) vl++;
            @(negedge clk);
        end
        chk({tag, "_stall_seen"}, st, 0);
        chk({tag, "_valid_seen"}, vl, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_cmd = C_ADD; i_value1 = '0; i_value2 = '0;
        i_dest = '0; i_wb = 1'b0; i_flush = 1'b0;
        #1;
        chk("reset_stall", {31'd0, o_stall}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        chk("reset_dest", {27'd0, o_dest}, 32'd0);
        chk("reset_wb", {31'd0, o_wb}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal multiplies and divides (back-to-back issue)
        run_op("mul",   C_MUL,   32'd7,        32'hFFFFFFFD, 5'd5,  1'b1, 32'hFFFFFFEB, 34);
        run_op("mulhu", C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  1'b1, 32'hFFFFFFFE, 34);
        run_op("mulh",  C_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b0, 32'h00000000, 34);
        run_op("div",   C_DIV,   32'hFFFFFFF9, 32'd2,        5'd8,  1'b1, 32'hFFFFFFFD, 34);
        run_op("rem",   C_REM,   32'hFFFFFFF9, 32'd2,        5'd9,  1'b1, 32'hFFFFFFFF, 34);
        run_op("divu",  C_DIVU,  32'd100,      32'd7,        5'd10, 1'b1, 32'd14,       34);
        run_op("remu",  C_REMU,  32'd100,      32'd7,        5'd11, 1'b1, 32'd2,        34);

        // Divide corner cases resolved at accept
        run_op("div0",  C_DIV,   32'd5,        32'd0,        5'd12, 1'b1, 32'hFFFFFFFF, 1);
        run_op("rem0",  C_REM,   32'd5,        32'd0,        5'd13, 1'b1, 32'd5,        1);
        run_op("divu0", C_DIVU,  32'd5,        32'd0,        5'd14, 1'b1, 32'hFFFFFFFF, 1);
        run_op("remu0", C_REMU,  32'd5,        32'd0,        5'd15, 1'b0, 32'd5,        1);
        run_op("divov", C_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b1, 32'h80000000, 1);
        run_op("remov", C_REM,   32'h80000000, 32'hFFFFFFFF, 5'd17, 1'b1, 32'd0,        1);

        // Flush on CALC cycle 10
        @(negedge clk);
        i_valid = 1'b1; i_cmd = C_MUL; i_value1 = 32'd3; i_value2 = 32'd5; i_dest = 5'd18; i_wb = 1'b1;
        #1;
        chk("flush_accept_stall", {31'd0, o_stall}, 32'd1);
        repeat (10) @(negedge clk);
        #1;
        chk("flush_pre_stall", {31'd0, o_stall}, 32'd1);
        i_flush = 1'b1;
        #1;
        chk("flush_cycle_stall", {31'd0, o_stall}, 32'd0);
        chk("flush_cycle_valid", {31'd0, o_valid}, 32'd0);
        @(negedge clk);
        i_flush = 1'b0; i_valid = 1'b0;
        watch_quiet("flush_after", 40);
        run_op("divu_after_flush", C_DIVU, 32'd9, 32'd3, 5'd19, 1'b1, 32'd3, 34);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        i_valid = 1'b1; i_cmd = C_DIV; i_value1 = 32'd100; i_value2 = 32'd7; i_dest = 5'd20; i_wb = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("pre_reset_result_held", o_result, 32'd3);
        chk("pre_reset_dest", {27'd0, o_dest}, 32'd20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", {31'd0, o_stall}, 32'd0);
        chk("midreset_valid", {31'd0, o_valid}, 32'd0);
        chk("midreset_result", o_result, 32'd0);
        chk("midreset_dest", {27'd0, o_dest}, 32'd0);
        chk("midreset_wb", {31'd0, o_wb}, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Non-muldiv command is ignored
        @(negedge clk);
        i_valid = 1'b1; i_cmd = C_ADD; i_value1 = 32'd1; i_value2 = 32'd2; i_dest = 5'd21; i_wb = 1'b1;
        watch_quiet("add_ignored", 40);
        i_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
